// File: rtl/vend_ctrl_multi_if.sv
// Coin, select, restock and change-handshake signals of the multi-item vending controller.
interface vend_ctrl_multi_if #(
  parameter int unsigned ITEM_W   = 2,
  parameter int unsigned CREDIT_W = 8
);
  logic                coin_valid;
  logic [1:0]          coin_sel;
  logic                sel_valid;
  logic [ITEM_W-1:0]   sel_item;
  logic                cancel;
  logic                restock_valid;
  logic [ITEM_W-1:0]   restock_item;
  logic                chg_ready;
  logic                chg_valid;
  logic [1:0]          chg_coin;
  logic                vend;
  logic [ITEM_W-1:0]   vend_item;
  logic                coin_reject;
  logic                sold_out;
  logic                short_credit;
  logic [CREDIT_W-1:0] credit;
  logic                busy;

  modport slave (
    input  coin_valid, coin_sel, sel_valid, sel_item, cancel,
           restock_valid, restock_item, chg_ready,
    output chg_valid, chg_coin, vend, vend_item, coin_reject,
           sold_out, short_credit, credit, busy
  );

  modport master (
    output coin_valid, coin_sel, sel_valid, sel_item, cancel,
           restock_valid, restock_item, chg_ready,
    input  chg_valid, chg_coin, vend, vend_item, coin_reject,
           sold_out, short_credit, credit, busy
  );
endinterface

// File: rtl/vend_ctrl_multi.sv
// Multi-item vending controller: credit accumulator, per-item stock, cancel/refund and
// valid/ready change dispensing. Every output is driven straight from a register.
module vend_ctrl_multi #(
  parameter int unsigned NUM_ITEMS  = 4,
  parameter int unsigned ITEM_W     = 2,
  parameter int unsigned CREDIT_W   = 8,
  parameter int unsigned PRICE      = 10,
  parameter int unsigned MAX_CREDIT = 95,
  parameter int unsigned STOCK_W    = 4,
  parameter int unsigned STOCK_MAX  = 15
) (
  input logic              clk,
  input logic              reset,
  vend_ctrl_multi_if.slave bus
);
  localparam int unsigned SUM_W = CREDIT_W + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [ITEM_W-1:0]   item_q, item_d;
  logic [STOCK_W-1:0]  stock_q [NUM_ITEMS];
  logic [STOCK_W-1:0]  stock_d [NUM_ITEMS];
  logic                vend_q, vend_d;
  logic                coin_reject_q, coin_reject_d;
  logic                sold_out_q, sold_out_d;
  logic                short_credit_q, short_credit_d;
  logic                chg_valid_q, chg_valid_d;
  logic [1:0]          chg_coin_q, chg_coin_d;
  logic                busy_q, busy_d;
  logic [SUM_W-1:0]    coin_sum;
  logic                sel_ok;

  // Coin code to TK: 00=5, 01=10, 10=20, 11=50
  function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] code);
    logic [CREDIT_W-1:0] v;
    v = CREDIT_W'(5);
    case (code)
      2'b01:   v = CREDIT_W'(10);
      2'b10:   v = CREDIT_W'(20);
      2'b11:   v = CREDIT_W'(50);
      default: v = CREDIT_W'(5);
    endcase
    return v;
  endfunction

  // Largest change coin not exceeding the credit; credit is always a multiple of 5
  function automatic logic [1:0] greedy_coin(input logic [CREDIT_W-1:0] c);
    logic [1:0] code;
    if (c >= CREDIT_W'(20))      code = 2'b10;
    else if (c >= CREDIT_W'(10)) code = 2'b01;
    else                         code = 2'b00;
    return code;
  endfunction

  assign coin_sum = SUM_W'(credit_q) + SUM_W'(coin_value(bus.coin_sel));
  assign sel_ok   = (32'(bus.sel_item) < NUM_ITEMS) && (stock_q[bus.sel_item] != '0);

  // Next-state, credit, stock and pulse decode
  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    item_d         = item_q;
    stock_d        = stock_q;
    vend_d         = 1'b0;
    coin_reject_d  = 1'b0;
    sold_out_d     = 1'b0;
    short_credit_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.cancel) begin
          coin_reject_d = bus.coin_valid;
          if (credit_q != '0) state_d = CHANGE;
        end else if (bus.sel_valid) begin
          coin_reject_d = bus.coin_valid;
          if (!sel_ok) begin
            sold_out_d = 1'b1;
          end else if (credit_q < CREDIT_W'(PRICE)) begin
            short_credit_d = 1'b1;
          end else begin
            state_d = VEND;
            item_d  = bus.sel_item;
          end
        end else if (bus.coin_valid) begin
          if (coin_sum > SUM_W'(MAX_CREDIT)) coin_reject_d = 1'b1;
          else                               credit_d      = coin_sum[CREDIT_W-1:0];
        end
      end
      VEND: begin
        coin_reject_d   = bus.coin_valid;
        vend_d          = 1'b0;
        credit_d        = credit_q - CREDIT_W'(PRICE);
        stock_d[item_q] = stock_q[item_q] - STOCK_W'(1);
        state_d         = (credit_d != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        coin_reject_d = bus.coin_valid;
        if (chg_valid_q && bus.chg_ready) begin
          credit_d = credit_q - coin_value(chg_coin_q);
          if (credit_d == '0) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Applied after the vend decrement so a coincident restock of the same slot wins
    if (bus.restock_valid && (32'(bus.restock_item) < NUM_ITEMS))
      stock_d[bus.restock_item] = STOCK_W'(STOCK_MAX);

    vend_d      = (state_d == VEND);
    chg_valid_d = (state_d == CHANGE);
    chg_coin_d  = chg_valid_d ? greedy_coin(credit_d) : 2'b00;
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      credit_q       <= '0;
      item_q         <= '0;
      for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= STOCK_W'(STOCK_MAX);
      vend_q         <= 1'b0;
      coin_reject_q  <= 1'b0;
      sold_out_q     <= 1'b0;
      short_credit_q <= 1'b0;
      chg_valid_q    <= 1'b0;
      chg_coin_q     <= 2'b00;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      item_q         <= item_d;
      stock_q        <= stock_d;
      vend_q         <= vend_d;
      coin_reject_q  <= coin_reject_d;
      sold_out_q     <= sold_out_d;
      short_credit_q <= short_credit_d;
      chg_valid_q    <= chg_valid_d;
      chg_coin_q     <= chg_coin_d;
      busy_q         <= busy_d;
    end
  end

  assign bus.chg_valid    = chg_valid_q;
  assign bus.chg_coin     = chg_coin_q;
  assign bus.vend         = vend_q;
  assign bus.vend_item    = item_q;
  assign bus.coin_reject  = coin_reject_q;
  assign bus.sold_out     = sold_out_q;
  assign bus.short_credit = short_credit_q;
  assign bus.credit       = credit_q;
  assign bus.busy         = busy_q;
endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Bench for vend_ctrl_multi: directed vector table, hand sequences for drain/restock/reset,
// then random traffic against a transaction-level model of the vending rules.
module tb_vend_ctrl_multi;
  localparam int NUM_ITEMS  = 4;
  localparam int PRICE      = 10;
  localparam int MAX_CREDIT = 95;
  localparam int STOCK_MAX  = 15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vend_ctrl_multi_if #(.ITEM_W(2), .CREDIT_W(8)) bus ();

  vend_ctrl_multi #(
    .NUM_ITEMS(4), .ITEM_W(2), .CREDIT_W(8), .PRICE(10),
    .MAX_CREDIT(95), .STOCK_W(4), .STOCK_MAX(15)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: money and stock as plain integers, plus what the machine is busy doing
  int m_credit;
  int m_stock [NUM_ITEMS];
  int m_item;
  bit m_vend_pending;
  bit m_refunding;
  int e_vend, e_rej, e_sold, e_short;

  typedef struct {
    logic       cv;  logic [1:0] cs; logic sv; logic [1:0] si; logic can; logic rdy;
    int         credit; logic vend; int vitem; logic rej; logic sold; logic shrt;
    logic       chgv; logic [1:0] chgc; logic busy;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t r(logic cv, logic [1:0] cs, logic sv, logic [1:0] si, logic can,
                             logic rdy, int credit, logic vend, int vitem, logic rej,
                             logic sold, logic shrt, logic chgv, logic [1:0] chgc, logic busy);
    vec_t v;
    v.cv = cv; v.cs = cs; v.sv = sv; v.si = si; v.can = can; v.rdy = rdy;
    v.credit = credit; v.vend = vend; v.vitem = vitem; v.rej = rej; v.sold = sold;
    v.shrt = shrt; v.chgv = chgv; v.chgc = chgc; v.busy = busy;
    return v;
  endfunction

  function automatic int coin_tk(logic [1:0] code);
    int tk[4] = '{5, 10, 20, 50};
    return tk[code];
  endfunction

  function automatic int change_code(int c);
    int tk[3] = '{20, 10, 5};
    int code[3] = '{2, 1, 0};
    for (int i = 0; i < 3; i++) if (tk[i] <= c) return code[i];
    return 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    int v;
    e_vend = 0; e_rej = 0; e_sold = 0; e_short = 0;
    if (reset) begin
      m_credit = 0; m_item = 0; m_vend_pending = 0; m_refunding = 0;
      for (int i = 0; i < NUM_ITEMS; i++) m_stock[i] = STOCK_MAX;
    end else begin
      v = coin_tk(bus.coin_sel);
      if (m_vend_pending) begin
        e_rej = bus.coin_valid;
        m_credit -= PRICE;
        m_stock[m_item]--;
        m_vend_pending = 0;
        m_refunding = (m_credit > 0);
      end else if (m_refunding) begin
        e_rej = bus.coin_valid;
        if (bus.chg_ready) begin
          m_credit -= coin_tk(2'(change_code(m_credit)));
          m_refunding = (m_credit > 0);
        end
      end else if (bus.cancel) begin
        e_rej = bus.coin_valid;
        m_refunding = (m_credit > 0);
      end else if (bus.sel_valid) begin
        e_rej = bus.coin_valid;
        if (int'(bus.sel_item) >= NUM_ITEMS || m_stock[bus.sel_item] == 0) e_sold = 1;
        else if (m_credit < PRICE) e_short = 1;
        else begin
          m_vend_pending = 1;
          m_item = int'(bus.sel_item);
        end
      end else if (bus.coin_valid) begin
        if (m_credit + v > MAX_CREDIT) e_rej = 1;
        else m_credit += v;
      end
      if (bus.restock_valid && int'(bus.restock_item) < NUM_ITEMS)
        m_stock[bus.restock_item] = STOCK_MAX;
    end
    e_vend = int'(m_vend_pending);
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".credit"},       32'(bus.credit),       32'(m_credit));
    chk({tag, ".vend"},         32'(bus.vend),         32'(e_vend));
    chk({tag, ".vend_item"},    32'(bus.vend_item),    32'(m_item));
    chk({tag, ".coin_reject"},  32'(bus.coin_reject),  32'(e_rej));
    chk({tag, ".sold_out"},     32'(bus.sold_out),     32'(e_sold));
    chk({tag, ".short_credit"}, 32'(bus.short_credit), 32'(e_short));
    chk({tag, ".chg_valid"},    32'(bus.chg_valid),    32'(m_refunding));
    chk({tag, ".chg_coin"},     32'(bus.chg_coin),     m_refunding ? 32'(change_code(m_credit)) : 32'd0);
    chk({tag, ".busy"},         32'(bus.busy),         32'(m_vend_pending || m_refunding));
  endtask

  task automatic drive(input logic cv, input logic [1:0] cs, input logic sv, input logic [1:0] si,
                       input logic can, input logic rv, input logic [1:0] ri, input logic rdy);
    bus.coin_valid = cv; bus.coin_sel = cs; bus.sel_valid = sv; bus.sel_item = si;
    bus.cancel = can; bus.restock_valid = rv; bus.restock_item = ri; bus.chg_ready = rdy;
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic idle_inputs();
    drive(0, 2'd0, 0, 2'd0, 0, 0, 2'd0, 0);
  endtask

  // Insert 10 TK, select the item, let VEND complete
  task automatic buy(input logic [1:0] item, input bit expect_vend, input string tag);
    drive(1, 2'd1, 0, 2'd0, 0, 0, 2'd0, 1); tick(tag);
    drive(0, 2'd0, 1, item, 0, 0, 2'd0, 1); tick(tag);
    chk({tag, ".vend_pulse"}, 32'(bus.vend), 32'(expect_vend));
    idle_inputs(); tick(tag);
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    tick("reset");
    tick("reset");
    chk("reset.credit", 32'(bus.credit), 32'd0);
    chk("reset.busy", 32'(bus.busy), 32'd0);
    chk("reset.chg_valid", 32'(bus.chg_valid), 32'd0);
    reset = 1'b0;

    tv.push_back(r(1,0,0,0,0,0,  5,0,0,0,0,0,0,0,0));
    tv.push_back(r(1,0,0,0,0,0, 10,0,0,0,0,0,0,0,0));
    tv.push_back(r(0,0,1,1,0,0, 10,1,1,0,0,0,0,0,1));
    tv.push_back(r(0,0,0,0,0,0,  0,0,1,0,0,0,0,0,0));
    tv.push_back(r(1,3,0,0,0,0, 50,0,1,0,0,0,0,0,0));
    tv.push_back(r(0,0,1,0,0,1, 50,1,0,0,0,0,0,0,1));
    tv.push_back(r(0,0,0,0,0,1, 40,0,0,0,0,0,1,2,1));
    tv.push_back(r(0,0,0,0,0,1, 20,0,0,0,0,0,1,2,1));
    tv.push_back(r(0,0,0,0,0,1,  0,0,0,0,0,0,0,0,0));
    tv.push_back(r(1,2,0,0,0,0, 20,0,0,0,0,0,0,0,0));
    tv.push_back(r(1,1,0,0,0,0, 30,0,0,0,0,0,0,0,0));
    tv.push_back(r(1,0,0,0,0,0, 35,0,0,0,0,0,0,0,0));
    tv.push_back(r(0,0,0,0,1,0, 35,0,0,0,0,0,1,2,1));
    tv.push_back(r(0,0,0,0,0,0, 35,0,0,0,0,0,1,2,1));
    tv.push_back(r(0,0,0,0,0,0, 35,0,0,0,0,0,1,2,1));
    tv.push_back(r(0,0,0,0,0,0, 35,0,0,0,0,0,1,2,1));
    tv.push_back(r(0,0,0,0,0,1, 15,0,0,0,0,0,1,1,1));
    tv.push_back(r(0,0,0,0,0,1,  5,0,0,0,0,0,1,0,1));
    tv.push_back(r(0,0,0,0,0,1,  0,0,0,0,0,0,0,0,0));
    tv.push_back(r(1,3,0,0,0,0, 50,0,0,0,0,0,0,0,0));
    tv.push_back(r(1,2,0,0,0,0, 70,0,0,0,0,0,0,0,0));
    tv.push_back(r(1,2,0,0,0,0, 90,0,0,0,0,0,0,0,0));
    tv.push_back(r(1,1,0,0,0,0, 90,0,0,1,0,0,0,0,0));
    tv.push_back(r(0,0,0,0,1,1, 90,0,0,0,0,0,1,2,1));
    tv.push_back(r(0,0,0,0,0,1, 70,0,0,0,0,0,1,2,1));
    tv.push_back(r(0,0,0,0,0,1, 50,0,0,0,0,0,1,2,1));
    tv.push_back(r(0,0,0,0,0,1, 30,0,0,0,0,0,1,2,1));
    tv.push_back(r(0,0,0,0,0,1, 10,0,0,0,0,0,1,1,1));
    tv.push_back(r(0,0,0,0,0,1,  0,0,0,0,0,0,0,0,0));
    tv.push_back(r(1,1,0,0,0,0, 10,0,0,0,0,0,0,0,0));
    tv.push_back(r(1,0,1,3,0,0, 10,1,3,1,0,0,0,0,1));
    tv.push_back(r(0,0,0,0,0,0,  0,0,3,0,0,0,0,0,0));
    tv.push_back(r(1,0,0,0,0,0,  5,0,3,0,0,0,0,0,0));
    tv.push_back(r(0,0,1,0,0,0,  5,0,3,0,0,1,0,0,0));
    tv.push_back(r(1,0,1,0,1,0,  5,0,3,1,0,0,1,0,1));
    tv.push_back(r(0,0,0,0,0,1,  0,0,3,0,0,0,0,0,0));

    foreach (tv[i]) begin
      drive(tv[i].cv, tv[i].cs, tv[i].sv, tv[i].si, tv[i].can, 0, 2'd0, tv[i].rdy);
      tick("vec");
      chk($sformatf("vec%0d.credit", i),       32'(bus.credit),       32'(tv[i].credit));
      chk($sformatf("vec%0d.vend", i),         32'(bus.vend),         32'(tv[i].vend));
      chk($sformatf("vec%0d.vend_item", i),    32'(bus.vend_item),    32'(tv[i].vitem));
      chk($sformatf("vec%0d.coin_reject", i),  32'(bus.coin_reject),  32'(tv[i].rej));
      chk($sformatf("vec%0d.sold_out", i),     32'(bus.sold_out),     32'(tv[i].sold));
      chk($sformatf("vec%0d.short_credit", i), 32'(bus.short_credit), 32'(tv[i].shrt));
      chk($sformatf("vec%0d.chg_valid", i),    32'(bus.chg_valid),    32'(tv[i].chgv));
      chk($sformatf("vec%0d.chg_coin", i),     32'(bus.chg_coin),     32'(tv[i].chgc));
      chk($sformatf("vec%0d.busy", i),         32'(bus.busy),         32'(tv[i].busy));
    end

    // Drain slot 2, then a further select must report sold out and keep the credit
    for (int i = 0; i < STOCK_MAX; i++) buy(2'd2, 1'b1, "drain");
    drive(1, 2'd1, 0, 2'd0, 0, 0, 2'd0, 1); tick("drain");
    drive(0, 2'd0, 1, 2'd2, 0, 0, 2'd0, 1); tick("drain");
    chk("drain.sold_out", 32'(bus.sold_out), 32'd1);
    chk("drain.credit_kept", 32'(bus.credit), 32'd10);

    // Restock, buy slot 2 and restock it again during the VEND cycle
    drive(0, 2'd0, 0, 2'd0, 0, 1, 2'd2, 1); tick("restock");
    drive(0, 2'd0, 1, 2'd2, 0, 0, 2'd0, 1); tick("restock");
    chk("restock.vend", 32'(bus.vend), 32'd1);
    drive(0, 2'd0, 0, 2'd0, 0, 1, 2'd2, 1); tick("restock");
    for (int i = 0; i < STOCK_MAX; i++) buy(2'd2, 1'b1, "refill");
    drive(1, 2'd1, 0, 2'd0, 0, 0, 2'd0, 1); tick("refill");
    drive(0, 2'd0, 1, 2'd2, 0, 0, 2'd0, 1); tick("refill");
    chk("refill.sold_out", 32'(bus.sold_out), 32'd1);

    // Credit 30 refund stalled, then reset abandons it
    drive(1, 2'd2, 0, 2'd0, 0, 0, 2'd0, 0); tick("rstchg");
    chk("rstchg.credit", 32'(bus.credit), 32'd30);
    drive(0, 2'd0, 0, 2'd0, 1, 0, 2'd0, 0); tick("rstchg");
    chk("rstchg.chg_valid", 32'(bus.chg_valid), 32'd1);
    reset = 1'b1;
    idle_inputs(); tick("rstchg");
    chk("rstchg.credit0", 32'(bus.credit), 32'd0);
    chk("rstchg.chg_valid0", 32'(bus.chg_valid), 32'd0);
    chk("rstchg.chg_coin0", 32'(bus.chg_coin), 32'd0);
    chk("rstchg.busy0", 32'(bus.busy), 32'd0);
    chk("rstchg.vend_item0", 32'(bus.vend_item), 32'd0);
    reset = 1'b0;

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      drive(($urandom_range(0, 9) < 4), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 9) < 2), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 29) == 0), ($urandom_range(0, 39) == 0),
            2'($urandom_range(0, 3)), ($urandom_range(0, 2) != 0));
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vend_ctrl_multi.md
Name: vend_ctrl_multi

Overview:
- Parametrised successor to the single-price vending FSM: multi-item vending controller with a credit accumulator, per-item stock counters, cancel/refund and handshaked change dispensing.
- Sits between the coin acceptor front-end and the dispense/change actuators.
- All outputs are registered.
- Money is in TK; every value is a multiple of 5.

Parameters:
- NUM_ITEMS, 4, number of product slots (>=2).
- ITEM_W, 2, width of the item index; equals clog2(NUM_ITEMS).
- CREDIT_W, 8, credit register width.
- PRICE, 10, item price in TK; multiple of 5, >0.
- MAX_CREDIT, 95, maximum credit held; multiple of 5, <= 2^CREDIT_W-1, >= PRICE.
- STOCK_W, 4, per-item stock counter width.
- STOCK_MAX, 15, value loaded on restock and at reset.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- coin_valid  in  1  one coin presented this cycle.
- coin_sel  in  2  coin value: 00=5, 01=10, 10=20, 11=50 TK.
- sel_valid  in  1  purchase request.
- sel_item  in  ITEM_W  requested item index.
- cancel  in  1  refund request.
- restock_valid  in  1  restock request.
- restock_item  in  ITEM_W  item index to refill.
- chg_ready  in  1  change actuator accepts a coin.
- chg_valid  out  1  change coin offered.
- chg_coin  out  2  change coin value: 00=5, 01=10, 10=20.
- vend  out  1  one-cycle dispense pulse.
- vend_item  out  ITEM_W  item dispensed; valid with vend.
- coin_reject  out  1  one-cycle pulse; presented coin is returned.
- sold_out  out  1  one-cycle pulse; selected item has zero stock.
- short_credit  out  1  one-cycle pulse; credit < PRICE on select.
- credit  out  CREDIT_W  current credit.
- busy  out  1  high in VEND and CHANGE states.

Behaviour:
- Reset: state IDLE; credit=0; all stock=STOCK_MAX; all outputs 0 (chg_coin=00, vend_item=0).
- Reset mid-CHANGE abandons the refund; credit is lost.
- Pulses are registered: an event sampled at edge k shows its response during cycle k+1.
- States: IDLE, VEND, CHANGE.
- IDLE priority per cycle: cancel > sel_valid > coin_valid. Only the highest-priority event is acted on.
  - A coin presented with a higher-priority event gives coin_reject.
  - A sel_valid dropped because of cancel is ignored silently.
- IDLE cancel: credit>0 -> CHANGE; credit=0 -> no effect.
- IDLE select, checked in order:
  - stock[sel_item]==0 -> sold_out pulse, stay IDLE, credit unchanged.
  - credit<PRICE -> short_credit pulse, stay IDLE.
  - Otherwise -> VEND.
- VEND lasts exactly one cycle, with:
  - vend=1 and vend_item=latched item.
  - stock[item] decremented by 1.
  - credit reduced by PRICE.
  - Next state: CHANGE if the remaining credit >0, else IDLE.
- IDLE coin:
  - credit+value <= MAX_CREDIT -> credit += value.
  - Otherwise coin_reject pulse, credit unchanged. The sum is computed one bit wider; no wrap.
- Coins presented in VEND or CHANGE -> coin_reject. sel_valid and cancel are ignored while busy.
- CHANGE: chg_valid=1.
  - chg_coin is the greedy largest of 20/10/5 that is <= credit; it is recomputed from the registered credit every cycle.
  - On chg_valid && chg_ready: credit -= coin value.
  - When credit reaches 0 -> IDLE, and chg_valid drops the next cycle.
  - chg_valid stays high and chg_coin stable while chg_ready=0 (valid/ready; no drop without acceptance).
- Restock is accepted in any state: stock[restock_item] <= STOCK_MAX.
  - If it coincides with the VEND decrement of the same item, restock wins (result STOCK_MAX).
- Out-of-range item index (>=NUM_ITEMS) on select -> sold_out. On restock -> ignored.
- credit never exceeds MAX_CREDIT and never underflows.

Test Plan:
- Coins 5, 5, then select item 1 -> credit 5, 10; vend=1, vend_item=1 one cycle after the select edge; credit 0; stock[1]=14; return to IDLE, no chg_valid.
- Coin 50, select item 0, chg_ready=1 -> vend; credit 40; chg_coin 20, 20; then IDLE with credit 0.
- Credit 35, cancel, chg_ready low for 3 cycles then high -> chg_valid=1 with chg_coin=20 held stable through the stall; then coins 10, 5; busy drops after the last accept.
- Credit 90, coin 10 -> coin_reject, credit 90. Same cycle sel_valid and coin 5 at credit 10 -> vend and coin_reject together.
- Drain item 2 with 15 purchases, then select item 2 -> sold_out, credit kept. Restock item 2 in the same cycle as a VEND of item 2 -> stock=15.
- Credit 5, select -> short_credit. Reset asserted during CHANGE with credit 30 -> next cycle all outputs 0, credit 0, state IDLE.
